shift_reg: RTL and testbench
============================

Name: shift_reg

Overview:
- Fixed-latency delay line: a W-bit word presented on in appears unchanged on out exactly D clock cycles later.
- Used as the output pipeline of the floating-point arithmetic units (e.g. the adder's result is delayed by the FP_ADD_LAT latency define) to model multi-cycle datapath latency.
- No handshake and no stall: every cycle shifts.

Parameters:
- W, 32, data width in bits (>=1); typical values 32 and 64.
- D, 1, delay depth in clock cycles (>=0). D=0 means a combinational pass-through.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset; clears all stages
- in  input  W  data word entering the delay line
- out  output  W  data word delayed by D cycles

Behaviour:
- Structure: D registers of W bits, stage[0]..stage[D-1].
  - Each rising clk edge: stage[0] <= in, and stage[i] <= stage[i-1] for i=1..D-1.
  - out = stage[D-1].
- Latency: a value sampled on in at rising edge k is visible on out after edge k+D-1, i.e. out at cycle k+D equals in at cycle k. Throughput is one word per cycle, with no bubbles.
- Reset:
  - When reset=1, all stages clear to 0 immediately, independent of clk, so out=0 asynchronously.
  - While reset is held, the stages stay 0 and in is ignored.
  - On the first rising edge after reset deasserts, stage[0] captures in. out then shows 0 for the D-1 following cycles, until the first captured word arrives.
- Reset mid-operation: all in-flight words are discarded; no partially shifted data survives.
- D=0:
  - out = in combinationally, with no registers.
  - reset has no effect on out.
  - clk is unused.
- D=1: single register, out = in delayed one cycle.
- Data is passed bit-exact. There is no interpretation, no sign extension and no width change.
- X on in propagates as X through the stages. Reset always yields a defined 0.
- No enable: the pipeline advances every cycle. Callers that need qualification carry a valid bit in a parallel instance with W=1.

Test Plan:
- W=32, D=3: assert reset for 2 cycles, then release. Drive in = 0x00000001, 0x00000002, 0x00000003, ... on consecutive cycles -> out is 0 for the first 3 edges after release, then 0x00000001, 0x00000002, ... one per cycle, with no gaps.
- W=64, D=4: drive in = 0xDEADBEEFCAFEF00D for one cycle, then 0 -> out equals 0xDEADBEEFCAFEF00D for exactly one cycle, 4 cycles later; otherwise out is 0.
- W=32, D=3, reset mid-stream: with pipeline full of 0xAAAAAAAA/0xBBBBBBBB/0xCCCCCCCC, raise reset between clock edges -> out goes to 0 immediately, without waiting for a clock edge. After release and feeding 0x12345678, out reads 0 for the first 3 cycles, then 0x12345678.
- W=8, D=0: sweep in 0x00..0xFF, toggling reset randomly -> out == in in the same delta cycle, unaffected by reset.
- W=32, D=1: random in each cycle for 1000 cycles -> out(t) == in(t-1) every cycle; scoreboard against a reference queue.
- W=1, D=8: walking single 1 -> out pulses high for one cycle exactly 8 cycles after input, confirming depth.

Source files
------------

// File: rtl/shift_reg_if.sv
// Data bundle for the shift_reg delay line: the word going in and the delayed word coming out.
interface shift_reg_if #(
    parameter int W = 32
);
    logic [W-1:0] in;
    logic [W-1:0] out;

    modport master (output in, input  out);
    modport slave  (input  in, output out);
endinterface

// File: rtl/shift_reg.sv
// Fixed-latency delay line: a W-bit word on bus.in reappears on bus.out D clocks later.
// D=0 degenerates to a combinational wire; the interface W must match this module's W.
module shift_reg #(
    parameter int W = 32,
    parameter int D = 1
) (
    input  logic       clk,
    input  logic       reset,
    shift_reg_if.slave bus
);
    generate
        if (D == 0) begin : g_pass
            // Clock and reset have no load in the pass-through build.
            logic w_unused;
            assign w_unused = clk ^ reset;
            assign bus.out  = bus.in;
        end else begin : g_pipe
            logic [W-1:0] r_stage [D];

            // NOTE: the stages are discrete flops, not a RAM, so every entry is cleared on reset.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < D; i++) r_stage[i] <= '0;
                end else begin
                    r_stage[0] <= bus.in;
                    for (int i = 1; i < D; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign bus.out = r_stage[D-1];
        end
    endgenerate
endmodule

// File: tb/tb_shift_reg.sv
// Self-checking bench: five shift_reg builds side by side, each scored against a queue model.
module tb_shift_reg;
    logic clk;
    logic rst;

    shift_reg_if #(.W(32)) if3 ();
    shift_reg_if #(.W(64)) if4 ();
    shift_reg_if #(.W(8))  if0 ();
    shift_reg_if #(.W(32)) if1 ();
    shift_reg_if #(.W(1))  if8 ();

    shift_reg #(.W(32), .D(3)) u_d3 (.clk(clk), .reset(rst), .bus(if3));
    shift_reg #(.W(64), .D(4)) u_d4 (.clk(clk), .reset(rst), .bus(if4));
    shift_reg #(.W(8),  .D(0)) u_d0 (.clk(clk), .reset(rst), .bus(if0));
    shift_reg #(.W(32), .D(1)) u_d1 (.clk(clk), .reset(rst), .bus(if1));
    shift_reg #(.W(1),  .D(8)) u_d8 (.clk(clk), .reset(rst), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: each queue holds the last D captured words, newest at the front.
    logic [63:0] hist3 [$];
    logic [63:0] hist4 [$];
    logic [63:0] hist1 [$];
    logic [63:0] hist8 [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        hist3.delete(); repeat (3) hist3.push_front('0);
        hist4.delete(); repeat (4) hist4.push_front('0);
        hist1.delete(); repeat (1) hist1.push_front('0);
        hist8.delete(); repeat (8) hist8.push_front('0);
    endtask

    task automatic set_rst(input logic v);
        rst = v;
        if (v) model_clear();
    endtask

    task automatic check_all();
        check("d3_out", {32'b0, if3.out}, hist3[$]);
        check("d4_out", if4.out, hist4[$]);
        check("d1_out", {32'b0, if1.out}, hist1[$]);
        check("d8_out", {63'b0, if8.out}, hist8[$]);
    endtask

    // One clock: capture inputs as seen at the edge, advance the model, then compare.
    task automatic tick();
        logic [63:0] a3, a4, a1, a8;
        logic        r;
        a3 = {32'b0, if3.in};
        a4 = if4.in;
        a1 = {32'b0, if1.in};
        a8 = {63'b0, if8.in};
        r  = rst;
        @(posedge clk);
        if (!r) begin
            hist3.push_front(a3); void'(hist3.pop_back());
            hist4.push_front(a4); void'(hist4.pop_back());
            hist1.push_front(a1); void'(hist1.pop_back());
            hist8.push_front(a8); void'(hist8.pop_back());
        end
        #1;
        check_all();
    endtask

    initial begin
        if3.in = '0; if4.in = '0; if0.in = '0; if1.in = '0; if8.in = '0;
        set_rst(1'b1);
        #1;
        check("rst_d3_zero", {32'b0, if3.out}, 64'h0);
        check_all();
        tick();
        tick();

        // W=32 D=3: counting stream after reset release
        set_rst(1'b0);
        for (int k = 1; k <= 10; k++) begin
            if3.in = k;
            tick();
            if (k == 2) check("d3_still_zero", {32'b0, if3.out}, 64'h0);
            if (k == 3) check("d3_first_word", {32'b0, if3.out}, 64'h1);
        end

        // W=64 D=4: single-cycle pulse
        if4.in = 64'hDEADBEEFCAFEF00D;
        tick();
        if4.in = '0;
        for (int k = 2; k <= 8; k++) begin
            tick();
            if (k == 4) check("d4_pulse", if4.out, 64'hDEADBEEFCAFEF00D);
            if (k == 5) check("d4_pulse_gone", if4.out, 64'h0);
        end

        // W=32 D=3: asynchronous reset with a full pipeline
        if3.in = 32'hAAAAAAAA; tick();
        if3.in = 32'hBBBBBBBB; tick();
        if3.in = 32'hCCCCCCCC; tick();
        check("d3_full", {32'b0, if3.out}, 64'hAAAAAAAA);
        #2;
        set_rst(1'b1);
        #1;
        check("d3_async_clear", {32'b0, if3.out}, 64'h0);
        check_all();
        tick();
        set_rst(1'b0);
        if3.in = 32'h12345678;
        tick();
        if3.in = '0;
        tick();
        check("d3_after_rst_zero", {32'b0, if3.out}, 64'h0);
        tick();
        check("d3_after_rst_word", {32'b0, if3.out}, 64'h12345678);
        tick();

        // W=8 D=0: pass-through sweep with reset toggling at random
        for (int v = 0; v < 256; v++) begin
            if0.in = v[7:0];
            rst = 1'($urandom_range(0, 1));
            #1;
            check("d0_pass", {56'b0, if0.out}, {56'b0, v[7:0]});
        end
        // Registered builds drifted during the sweep; re-align with a reset.
        set_rst(1'b1);
        #1;
        check_all();
        tick();
        set_rst(1'b0);

        // W=32 D=1 (and all others): random traffic
        for (int k = 0; k < 1000; k++) begin
            if1.in = $urandom;
            if3.in = $urandom;
            if4.in = {$urandom, $urandom};
            if8.in = 1'($urandom);
            tick();
        end

        // W=1 D=8: walking single one
        if1.in = '0; if3.in = '0; if4.in = '0;
        if8.in = 1'b0;
        repeat (9) tick();
        if8.in = 1'b1;
        tick();
        if8.in = 1'b0;
        for (int k = 2; k <= 12; k++) begin
            tick();
            if (k == 7) check("d8_before_pulse", {63'b0, if8.out}, 64'h0);
            if (k == 8) check("d8_pulse", {63'b0, if8.out}, 64'h1);
            if (k == 9) check("d8_after_pulse", {63'b0, if8.out}, 64'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
